// File: rtl/mac_accumulator_pkg.sv
// Shared types and constants for the MAC accumulator stage.
// Provides the FSM state encoding and the product zero-extension helper.
package mac_pkg;

    typedef enum logic {
        ACCUM = 1'b0,
        DONE  = 1'b1
    } state_t;

    localparam int OPND_W    = 4;
    localparam int PROD_W    = 8;
    localparam int ACC_MAX_W = 32;
    localparam int CNT_W     = 8;

    // Widened to the largest legal accumulator; callers cast down to ACC_W.
    function automatic logic [ACC_MAX_W-1:0] zext_prod(input logic [PROD_W-1:0] product);
        return {{(ACC_MAX_W-PROD_W){1'b0}}, product};
    endfunction

endpackage

// File: rtl/multiplier.sv
// Combinational 4x4 unsigned array multiplier with bit-level ports.
// Product bits are P0..P6 with CC5 as the most significant bit.
module multiplier (
    input  logic A0,
    input  logic A1,
    input  logic A2,
    input  logic A3,
    input  logic B0,
    input  logic B1,
    input  logic B2,
    input  logic B3,
    output logic P0,
    output logic P1,
    output logic P2,
    output logic P3,
    output logic P4,
    output logic P5,
    output logic P6,
    output logic CC5
);

    logic [3:0] a_v;
    logic [3:0] b_v;
    logic [7:0] prod;

    assign a_v = {A3, A2, A1, A0};
    assign b_v = {B3, B2, B1, B0};

    // NOTE: every variable assigned in always_comb gets a default first so no latch is inferred.
    always_comb begin
        prod = '0;
        for (int i = 0; i < 4; i++) begin
            if (b_v[i]) begin
                prod = prod + (8'(a_v) << i);
            end
        end
    end

    assign {CC5, P6, P5, P4, P3, P2, P1, P0} = prod;

endmodule

// File: rtl/mac_accumulator.sv
// MAC stage: registers operand pairs into the array multiplier and sums N_TERMS products.
// Define MAC_ACCUMULATOR_SATURATE_EN to saturate the accumulator instead of wrapping.
module mac_accumulator
    import mac_pkg::*;
#(
    parameter int ACC_W   = 12,
    parameter int N_TERMS = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       a,
    input  logic [3:0]       b,
    input  logic             clear,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] acc_out,
    output logic             ovf,
    output logic             busy
);

    state_t              state_q;
    state_t              state_d;
    logic                live_q;
    logic [OPND_W-1:0]   a_q;
    logic [OPND_W-1:0]   b_q;
    logic                p_valid;
    logic [PROD_W-1:0]   product;
    logic [ACC_W-1:0]    prod_ext;
    logic [ACC_W:0]      sum_full;
    logic [ACC_W-1:0]    acc_nxt;
    logic [ACC_W-1:0]    acc_q;
    logic [CNT_W-1:0]    count_q;
    logic                ovf_q;
    logic                in_fire;
    logic                out_fire;
    logic                last_add;
    logic                room;

    multiplier u_mult (
        .A0  (a_q[0]),
        .A1  (a_q[1]),
        .A2  (a_q[2]),
        .A3  (a_q[3]),
        .B0  (b_q[0]),
        .B1  (b_q[1]),
        .B2  (b_q[2]),
        .B3  (b_q[3]),
        .P0  (product[0]),
        .P1  (product[1]),
        .P2  (product[2]),
        .P3  (product[3]),
        .P4  (product[4]),
        .P5  (product[5]),
        .P6  (product[6]),
        .CC5 (product[7])
    );

    assign prod_ext = ACC_W'(zext_prod(product));
    assign sum_full = {1'b0, acc_q} + {1'b0, prod_ext};

`ifdef MAC_ACCUMULATOR_SATURATE_EN
    assign acc_nxt = sum_full[ACC_W] ? '1 : sum_full[ACC_W-1:0];
`else
    assign acc_nxt = sum_full[ACC_W-1:0];
`endif

    assign in_fire  = in_valid && in_ready;
    assign out_fire = out_valid && out_ready;
    assign last_add = p_valid && (count_q == CNT_W'(N_TERMS - 1));

    // Count the product already in flight so the final accepted term is exactly N_TERMS.
    assign room = ((CNT_W+1)'(count_q) + (CNT_W+1)'(p_valid)) < (CNT_W+1)'(N_TERMS);

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ACCUM;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (clear) begin
            state_d = ACCUM;
        end else begin
            case (state_q)
                ACCUM:   if (last_add)  state_d = DONE;
                DONE:    if (out_ready) state_d = ACCUM;
                default: state_d = ACCUM;
            endcase
        end
    end

    always_comb begin
        in_ready  = live_q && (state_q == ACCUM) && room;
        out_valid = (state_q == DONE);
        busy      = p_valid || (count_q != '0) || out_valid;
    end

    // NOTE: operand registers are reset along with the rest; they are few flops, not a memory array.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            live_q  <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            p_valid <= 1'b0;
            acc_q   <= '0;
            count_q <= '0;
            ovf_q   <= 1'b0;
        end else begin
            live_q <= 1'b1;
            if (clear) begin
                p_valid <= 1'b0;
                acc_q   <= '0;
                count_q <= '0;
                ovf_q   <= 1'b0;
            end else begin
                p_valid <= in_fire;
                if (in_fire) begin
                    a_q <= a;
                    b_q <= b;
                end
                if (out_fire) begin
                    acc_q   <= '0;
                    count_q <= '0;
                    ovf_q   <= 1'b0;
                end else if (p_valid) begin
                    acc_q   <= acc_nxt;
                    count_q <= count_q + CNT_W'(1);
                    if (sum_full[ACC_W]) begin
                        ovf_q <= 1'b1;
                    end
                end
            end
        end
    end

    assign acc_out = acc_q;
    assign ovf     = ovf_q;

endmodule

// File: tb/tb_mac_accumulator.sv
// Directed testbench for mac_accumulator: hand-computed sums, backpressure, clear and reset.
// A second ACC_W=10 instance observes wrap or saturation under MAC_ACCUMULATOR_SATURATE_EN.
module tb_mac_accumulator;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic [3:0]  a = '0;
    logic [3:0]  b = '0;
    logic        clear = 1'b0;
    logic        out_ready = 1'b0;

    logic        in_ready;
    logic        out_valid;
    logic [11:0] acc_out;
    logic        ovf;
    logic        busy;

    logic        in_ready10;
    logic        out_valid10;
    logic [9:0]  acc_out10;
    logic        ovf10;
    logic        busy10;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int xfers = 0;
    int first_acc;
    int xfers_before;

`ifdef MAC_ACCUMULATOR_SATURATE_EN
    localparam int EXP10 = 1023;
`else
    localparam int EXP10 = 776;
`endif

    mac_accumulator #(.ACC_W(12), .N_TERMS(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .clear     (clear),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .acc_out   (acc_out),
        .ovf       (ovf),
        .busy      (busy)
    );

    mac_accumulator #(.ACC_W(10), .N_TERMS(8)) dut10 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready10),
        .a         (a),
        .b         (b),
        .clear     (clear),
        .out_valid (out_valid10),
        .out_ready (out_ready),
        .acc_out   (acc_out10),
        .ovf       (ovf10),
        .busy      (busy10)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (out_valid && out_ready) xfers <= xfers + 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [3:0] av, input logic [3:0] bv);
        logic fire;
        int   guard;
        fire  = 1'b0;
        guard = 0;
        a = av;
        b = bv;
        in_valid = 1'b1;
        while (!fire && guard < 50) begin
            fire = in_ready;
            step();
            guard++;
        end
        if (!fire) check("send_timeout", 32'd0, 32'd1);
    endtask

    task automatic wait_result(input string tag, input logic [31:0] exp_acc, input logic exp_ovf);
        int guard;
        guard = 0;
        in_valid = 1'b0;
        while (!out_valid && guard < 40) begin
            step();
            guard++;
        end
        check({tag, "_valid"}, 32'(out_valid), 32'd1);
        check({tag, "_acc"}, 32'(acc_out), exp_acc);
        check({tag, "_ovf"}, 32'(ovf), 32'(exp_ovf));
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        repeat (3) step();
        check("rst_acc", 32'(acc_out), 32'd0);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_ovf", 32'(ovf), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd0);
        #4 rst_n = 1'b1;
        step();
        check("post_rst_in_ready", 32'(in_ready), 32'd1);

        // 8 x 15*15 back-to-back with the sink always ready
        out_ready = 1'b1;
        send(4'd15, 4'd15);
        first_acc = cyc;
        repeat (7) send(4'd15, 4'd15);
        check("max_no_extra_term", 32'(in_ready), 32'd0);
        in_valid = 1'b0;
        wait_result("max", 32'd1800, 1'b0);
        check("max_latency", 32'(cyc - first_acc + 1), 32'd9);
        check("max_done_in_ready", 32'(in_ready), 32'd0);
        check("max_busy", 32'(busy), 32'd1);
        check("w10_valid", 32'(out_valid10), 32'd1);
        check("w10_acc", 32'(acc_out10), 32'(EXP10));
        check("w10_ovf", 32'(ovf10), 32'd1);
        step();
        check("max_xfer_valid", 32'(out_valid), 32'd0);
        check("max_xfer_busy", 32'(busy), 32'd0);
        check("max_xfer_in_ready", 32'(in_ready), 32'd1);
        check("max_xfer_acc", 32'(acc_out), 32'd0);
        check("w10_xfer_ovf", 32'(ovf10), 32'd0);
        check("w10_xfer_ready", 32'(in_ready10), 32'd1);
        check("w10_xfer_busy", 32'(busy10), 32'd0);

        // backpressure: 8 x 3*5 held for 5 cycles
        out_ready = 1'b0;
        repeat (8) send(4'd3, 4'd5);
        wait_result("bp", 32'd120, 1'b0);
        for (int i = 0; i < 5; i++) begin
            step();
            check("bp_hold_acc", 32'(acc_out), 32'd120);
            check("bp_hold_valid", 32'(out_valid), 32'd1);
            check("bp_hold_in_ready", 32'(in_ready), 32'd0);
        end
        out_ready = 1'b1;
        step();
        check("bp_release_valid", 32'(out_valid), 32'd0);
        check("bp_release_acc", 32'(acc_out), 32'd0);

        // clear after 3 terms, with an input offered in the clear cycle
        xfers_before = xfers;
        repeat (3) send(4'd4, 4'd4);
        check("clr_partial_busy", 32'(busy), 32'd1);
        clear = 1'b1;
        a = 4'd9;
        b = 4'd9;
        in_valid = 1'b1;
        step();
        clear = 1'b0;
        in_valid = 1'b0;
        check("clr_acc", 32'(acc_out), 32'd0);
        check("clr_busy", 32'(busy), 32'd0);
        step();
        check("clr_dropped_input", 32'(acc_out), 32'd0);
        repeat (8) send(4'd1, 4'd2);
        wait_result("clr", 32'd16, 1'b0);
        step();
        check("clr_one_output", 32'(xfers - xfers_before), 32'd1);

        // asynchronous reset after 5 terms
        xfers_before = xfers;
        repeat (5) send(4'd15, 4'd15);
        in_valid = 1'b0;
        check("rstm_partial_acc", 32'(acc_out), 32'd900);
        #3 rst_n = 1'b0;
        #1;
        check("rstm_acc", 32'(acc_out), 32'd0);
        check("rstm_valid", 32'(out_valid), 32'd0);
        check("rstm_ovf", 32'(ovf), 32'd0);
        check("rstm_busy", 32'(busy), 32'd0);
        check("rstm_in_ready", 32'(in_ready), 32'd0);
        @(posedge clk);
        #3 rst_n = 1'b1;
        step();
        check("rstm_ready_back", 32'(in_ready), 32'd1);
        repeat (8) send(4'd15, 4'd1);
        wait_result("rstm", 32'd120, 1'b0);
        step();
        check("rstm_one_output", 32'(xfers - xfers_before), 32'd1);

        // gapped input: alternating 0*9 and 7*7 with idle cycles between
        for (int i = 0; i < 4; i++) begin
            send(4'd0, 4'd9);
            in_valid = 1'b0;
            step();
            send(4'd7, 4'd7);
            in_valid = 1'b0;
            step();
        end
        wait_result("gap", 32'd196, 1'b0);
        step();
        check("gap_xfer_valid", 32'(out_valid), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mac_accumulator.md
Name: mac_accumulator

Overview:
- Sequential stage that feeds the existing combinational 4x4 array multiplier (`multiplier`) and consumes its 8-bit product.
- Accepts 4-bit operand pairs through a valid/ready handshake and registers them into the multiplier inputs.
- Accumulates N_TERMS products into a wide register, then presents the sum with a valid/ready handshake.
- Top-level MAC stage of the course-project datapath, between the operand source and the result sink.

Parameters:
- ACC_W, 12, accumulator/result width in bits; legal range 8..32.
- N_TERMS, 8, products per dot-product; legal range 1..255.

Ports:
- clk  input  1  single rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  operand pair present.
- in_ready  output  1  block accepts an operand pair this cycle.
- a  input  4  operand A (a[0] is LSB, maps to A0).
- b  input  4  operand B (b[0] is LSB, maps to B0).
- clear  input  1  synchronous abort/clear.
- out_valid  output  1  acc_out holds a completed sum.
- out_ready  input  1  downstream accepts the sum.
- acc_out  output  ACC_W  accumulated sum.
- ovf  output  1  sticky overflow for the current sum.
- busy  output  1  at least one term is accepted and not yet delivered.

Behaviour:
- Reset: asynchronous on rst_n low.
  - All outputs and state go to 0: acc_out=0, out_valid=0, ovf=0, busy=0, in_ready=0, pipeline valid=0, term count=0, state=ACCUM.
  - in_ready rises in the first cycle after rst_n deasserts.
  - Reset mid-operation discards all partial work, with no output.
- Handshake rules:
  - Input transfer occurs on a clk edge with in_valid && in_ready.
  - Output transfer occurs on a clk edge with out_valid && out_ready.
  - acc_out and ovf are stable while out_valid=1 and out_ready=0.
- Pipeline:
  - Stage 1: operand registers a_q, b_q drive the multiplier; p_valid is set on input transfer.
  - Stage 2: when p_valid=1, the 8-bit product is zero-extended to ACC_W and added to acc, and the term count increments.
  - Latency: a product enters acc 2 edges after its acceptance. out_valid rises on the same edge that the N_TERMS-th product is added.
- State machine ACCUM:
  - in_ready = 1 while count + p_valid < N_TERMS, so no extra term is accepted beyond N_TERMS.
  - Full throughput: 1 pair/cycle.
  - Moves to DONE on the edge where the N_TERMS-th product is added.
- State machine DONE:
  - in_ready=0 and out_valid=1.
  - On output transfer: acc=0, count=0, ovf=0, out_valid=0, and the state returns to ACCUM. in_ready is 1 in the following cycle.
- Overflow (default): the addition wraps modulo 2^ACC_W. ovf is set if any carry out of bit ACC_W-1 occurs, and stays set until the output transfer or a clear.
- clear:
  - Has priority over all other events that cycle. It zeroes acc, count, ovf, p_valid and out_valid, and forces the state to ACCUM.
  - An input transfer in the same cycle is dropped.
  - A pending unaccepted result is discarded.
- busy = p_valid | (count != 0) | out_valid.
- Simultaneous events:
  - An input transfer on the edge that completes the N_TERMS-th add cannot happen, because in_ready is already 0 that cycle.
  - out_ready held high when DONE is entered transfers on the next edge.

Optional Feature:
- Macro: MAC_ACCUMULATOR_SATURATE_EN.
- Defined: on carry-out, acc saturates to all-ones (2^ACC_W - 1), holds there for the remaining terms, and ovf is still set.
- Undefined: wrap-around as described in Behaviour.

Decomposition:
- Package mac_pkg holds:
  - state enum {ACCUM, DONE};
  - OPND_W=4 and PROD_W=8 constants;
  - a function zext_prod(product) → ACC_W.
- One sub-module: the existing `multiplier` instance (combinational 4x4 array), wired from a_q/b_q bits to the product bits P0..P6 and CC5 (CC5 is the MSB).
- Accumulator adder and FSM stay inline.

Test Plan:
- Streaming max values: 8 pairs 15×15, back-to-back, out_ready=1 → acc_out=1800 (0x708), ovf=0, out_valid first high 9 edges after the first accept.
- Overflow: ACC_W=10, same stimulus → acc_out=776, ovf=1. With MAC_ACCUMULATOR_SATURATE_EN → acc_out=1023, ovf=1.
- Backpressure: hold out_ready=0 for 5 cycles after DONE (sum of 8×(3×5)=120).
  - acc_out=120 is stable and in_ready=0 throughout.
  - After release, the next sum starts from 0.
- clear mid-stream: clear pulsed after 3 terms, then 8×(1×2) → acc_out=16; no output occurs for the aborted partial sum.
- Reset mid-operation: rst_n pulsed low asynchronously (between edges) after 5 terms → all outputs 0 immediately. Then 8×(15×1) → acc_out=120.
- Gapped input: in_valid toggling 1/0 with pairs 0×9 and 7×7, alternating ×4 each → acc_out=196, ovf=0.
